// File: rtl/fxp_mult_pipe_if.sv
// Valid/ready stream bundle for the fixed-point multiplier: input sample channel plus result channel.
interface fxp_mult_pipe_if #(
  parameter int DATA_W = 13,
  parameter int COEF_W = 12
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [COEF_W-1:0] in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_z;
  logic                     out_ovf;

  // Producer of samples / consumer of results
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_z, out_ovf
  );

  // The multiplier pipeline itself
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_z, out_ovf
  );
endinterface

// File: rtl/fxp_mult_pipe.sv
// Three-stage signed fixed-point multiplier: operand register, full product, then
// round/shift with wrap or saturate; a single global advance stalls all stages together.
module fxp_mult_pipe #(
  parameter int DATA_W    = 13,
  parameter int COEF_W    = 12,
  parameter int COEF_FRAC = 10,
  parameter int ROUND     = 0,
  parameter int SAT       = 0
) (
  input  logic           clk,
  input  logic           rst,
  fxp_mult_pipe_if.slave bus,
  input  logic           clr_sticky,
  output logic           ovf_sticky
);

  localparam int unsigned PW = DATA_W + COEF_W;
  localparam int unsigned RW = PW + 1;
  localparam int unsigned HW = RW - DATA_W + 1;
  localparam logic [RW-1:0] RND_ADD = (ROUND != 0) ? (RW'(1) << (COEF_FRAC - 1)) : '0;
  localparam logic [DATA_W-1:0] Z_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] Z_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  if (COEF_FRAC < 1 || COEF_FRAC > COEF_W - 1) begin : g_bad_frac
    $error("fxp_mult_pipe: COEF_FRAC out of range 1..COEF_W-1");
  end

  logic                     adv_c;
  logic                     v1_q, v2_q, v3_q;
  logic signed [DATA_W-1:0] a_q;
  logic signed [COEF_W-1:0] b_q;
  logic signed [PW-1:0]     p_c, p_q;
  logic signed [RW-1:0]     sum_c, r_c;
  logic        [HW-1:0]     hi_c;
  logic                     ovf_c;
  logic        [DATA_W-1:0] z_c, z_q;
  logic                     ovf_q;
  logic                     sticky_q;

  // The whole pipe moves unless a held result is waiting on the consumer
  assign adv_c         = bus.out_ready || !v3_q;
  assign bus.in_ready  = adv_c;
  assign bus.out_valid = v3_q;
  assign bus.out_z     = z_q;
  assign bus.out_ovf   = ovf_q;
  assign ovf_sticky    = sticky_q;

  // Full-precision signed product
  always_comb begin
    p_c = $signed({{COEF_W{a_q[DATA_W-1]}}, a_q}) * $signed({{DATA_W{b_q[COEF_W-1]}}, b_q});
  end

  // One extra bit ahead of the rounding add keeps it from overflowing
  always_comb begin
    sum_c = $signed({p_q[PW-1], p_q}) + $signed(RND_ADD);
    r_c   = sum_c >>> COEF_FRAC;
    hi_c  = r_c[RW-1:DATA_W-1];
    ovf_c = !((&hi_c) || !(|hi_c));
    z_c   = r_c[DATA_W-1:0];
    if ((SAT != 0) && ovf_c) begin
      z_c = r_c[RW-1] ? Z_MIN : Z_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      z_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (adv_c) begin
        v1_q  <= bus.in_valid;
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
        v2_q  <= v1_q;
        p_q   <= p_c;
        v3_q  <= v2_q;
        z_q   <= z_c;
        ovf_q <= ovf_c;
      end
      // A transferred overflow beats a simultaneous clear
      if (v3_q && bus.out_ready && ovf_q) begin
        sticky_q <= 1'b1;
      end else if (clr_sticky) begin
        sticky_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Directed bench: four instances covering every ROUND/SAT combination share one stimulus
// stream and are checked against a hand-computed vector table plus multi-cycle sequences.
module tb_fxp_mult_pipe;

  localparam int unsigned DATA_W = 13;
  localparam int unsigned COEF_W = 12;
  localparam int unsigned ND     = 4;
  localparam int unsigned NV     = 13;

  typedef struct {
    int         a;
    int         b;
    int         z0;
    int         z1;
    int         z2;
    int         z3;
    logic [3:0] ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid;
  logic out_ready;
  logic clr_sticky;
  logic signed [DATA_W-1:0] in_a;
  logic signed [COEF_W-1:0] in_b;

  logic [ND-1:0]             irdy;
  logic [ND-1:0]             ovalid;
  logic [ND-1:0]             oovf;
  logic [ND-1:0]             osticky;
  logic [ND-1:0][DATA_W-1:0] oz;

  vec_t       tv[NV];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_sticky;

  always #5 clk = ~clk;

  // Instance g: ROUND = g/2, SAT = g%2
  for (genvar g = 0; g < ND; g++) begin : g_dut
    fxp_mult_pipe_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();
    assign bus.in_valid  = in_valid;
    assign bus.in_a      = in_a;
    assign bus.in_b      = in_b;
    assign bus.out_ready = out_ready;
    assign irdy[g]       = bus.in_ready;
    assign ovalid[g]     = bus.out_valid;
    assign oz[g]         = bus.out_z;
    assign oovf[g]       = bus.out_ovf;

    fxp_mult_pipe #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(10), .ROUND(g / 2), .SAT(g % 2)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave),
      .clr_sticky(clr_sticky),
      .ovf_sticky(osticky[g])
    );
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input int a, input int b, input int z0, input int z1,
                      input int z2, input int z3, input logic [3:0] o);
    tv[i].a = a; tv[i].b = b;
    tv[i].z0 = z0; tv[i].z1 = z1; tv[i].z2 = z2; tv[i].z3 = z3;
    tv[i].ovf = o;
  endtask

  function automatic int exp_z(input int i, input int g);
    case (g)
      0:       return tv[i].z0;
      1:       return tv[i].z1;
      2:       return tv[i].z2;
      default: return tv[i].z3;
    endcase
  endfunction

  function automatic int zval(input int g);
    logic signed [DATA_W-1:0] t;
    t = oz[g];
    return int'(t);
  endfunction

  task automatic chk_out(input string tag, input int i);
    for (int g = 0; g < ND; g++) begin
      chk($sformatf("%s v%0d dut%0d valid", tag, i, g), int'(ovalid[g]), 1);
      chk($sformatf("%s v%0d dut%0d z", tag, i, g), zval(g), exp_z(i, g));
      chk($sformatf("%s v%0d dut%0d ovf", tag, i, g), int'(oovf[g]), int'(tv[i].ovf[g]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int i);
    in_valid = 1'b1;
    in_a     = DATA_W'(tv[i].a);
    in_b     = COEF_W'(tv[i].b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int in_idx;
    int out_idx;
    int cyc;
    logic stalled;
    int held[ND];

    in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    in_a = '0; in_b = '0; rst = 1'b1;

    // a, b, z for (R0S0, R0S1, R1S0, R1S1), ovf bits per instance
    setv( 0,   512,   512,   256,   256,   256,   256, 4'b0000);
    setv( 1,     3,   512,     1,     1,     2,     2, 4'b0000);
    setv( 2,    -3,   512,    -2,    -2,    -1,    -1, 4'b0000);
    setv( 3, -4096, -1024, -4096,  4095, -4096,  4095, 4'b1111);
    setv( 4,  4095, -1024, -4095, -4095, -4095, -4095, 4'b0000);
    setv( 5,  4095,  2047,    -6,  4095,    -6,  4095, 4'b1111);
    setv( 6, -4096,  2047,     4, -4096,     4, -4096, 4'b1111);
    setv( 7,     0, -2048,     0,     0,     0,     0, 4'b0000);
    setv( 8,     1,   512,     0,     0,     1,     1, 4'b0000);
    setv( 9,    -1,     1,    -1,    -1,     0,     0, 4'b0000);
    setv(10,  4095,  1024,  4095,  4095,  4095,  4095, 4'b0000);
    setv(11, -4096,  1024, -4096, -4096, -4096, -4096, 4'b0000);
    setv(12,  2049,  2047,  4095,  4095, -4096,  4095, 4'b1100);

    @(negedge clk);
    tick();
    tick();
    chk("reset out_valid", int'(ovalid), 0);
    chk("reset out_ovf", int'(oovf), 0);
    chk("reset sticky", int'(osticky), 0);
    chk("reset in_ready", int'(irdy), 15);
    for (int g = 0; g < ND; g++) chk($sformatf("reset dut%0d z", g), zval(g), 0);
    rst = 1'b0;
    chk("post-reset in_ready", int'(irdy), 15);
    tick();
    chk("post-reset out_valid", int'(ovalid), 0);
    exp_sticky = 4'b0000;

    // Isolated samples: exact latency, value, overflow and sticky per vector
    for (int i = 0; i < int'(NV); i++) begin
      drive(i);
      #1;
      chk($sformatf("single v%0d in_ready", i), int'(irdy), 15);
      tick();
      in_valid = 1'b0;
      chk($sformatf("single v%0d lat1", i), int'(ovalid), 0);
      tick();
      chk($sformatf("single v%0d lat2", i), int'(ovalid), 0);
      tick();
      chk_out("single", i);
      exp_sticky = exp_sticky | tv[i].ovf;
      tick();
      chk($sformatf("single v%0d drained", i), int'(ovalid), 0);
      chk($sformatf("single v%0d sticky", i), int'(osticky), int'(exp_sticky));
    end

    // Continuous stream with backpressure and one bubble
    in_idx = 0; out_idx = 0; cyc = 0; stalled = 1'b0;
    while (out_idx < int'(NV) && cyc < 400) begin
      if (stalled) begin
        for (int g = 0; g < ND; g++) begin
          chk($sformatf("stall c%0d dut%0d valid", cyc, g), int'(ovalid[g]), 1);
          chk($sformatf("stall c%0d dut%0d z", cyc, g), zval(g), held[g]);
        end
      end
      if (cyc >= 4 && cyc <= 7) out_ready = 1'b0;
      else out_ready = 1'($urandom_range(0, 1));
      if (in_idx < int'(NV) && cyc != 2) drive(in_idx);
      else in_valid = 1'b0;
      #1;
      if (ovalid[0] && !out_ready) chk($sformatf("stall c%0d in_ready", cyc), int'(irdy), 0);
      stalled = ovalid[0] && !out_ready;
      for (int g = 0; g < ND; g++) held[g] = zval(g);
      if (ovalid[0] && out_ready) begin
        chk_out("stream", out_idx);
        out_idx++;
      end
      if (in_valid && irdy[0]) in_idx++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream result count", out_idx, int'(NV));
    tick();
    tick();
    chk("stream drained", int'(ovalid), 0);
    exp_sticky = 4'b1111;
    chk("stream sticky", int'(osticky), int'(exp_sticky));

    // Clear coincident with a transfer: overflowed instances keep the flag
    drive(12);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk_out("sticky", 12);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky set beats clear", int'(osticky), 12);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("sticky clear alone", int'(osticky), 0);

    // Reset with three overflowing samples in flight
    for (int k = 0; k < 3; k++) begin
      drive((k == 0) ? 3 : (k == 1) ? 5 : 6);
      tick();
    end
    in_valid = 1'b0;
    chk("pre-reset pipe full", int'(ovalid), 15);
    rst = 1'b1;
    tick();
    chk("mid reset out_valid", int'(ovalid), 0);
    chk("mid reset out_ovf", int'(oovf), 0);
    chk("mid reset sticky", int'(osticky), 0);
    chk("mid reset in_ready", int'(irdy), 15);
    for (int g = 0; g < ND; g++) chk($sformatf("mid reset dut%0d z", g), zval(g), 0);
    tick();
    rst = 1'b0;
    chk("after reset out_valid", int'(ovalid), 0);
    drive(4);
    #1;
    chk("after reset in_ready", int'(irdy), 15);
    tick();
    in_valid = 1'b0;
    chk("after reset lat1", int'(ovalid), 0);
    tick();
    chk("after reset lat2", int'(ovalid), 0);
    tick();
    chk_out("after reset", 4);
    tick();
    chk("after reset drained", int'(ovalid), 0);
    chk("after reset sticky", int'(osticky), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fxp_mult_pipe.md
FXP_MULT_PIPE -- requirements
Module: fxp_mult_pipe

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 13, meaning the width of signed data input and output.
REQ-002 The block SHALL expose parameter COEF_W, default 12, meaning the width of the signed coefficient input.
REQ-003 The block SHALL expose parameter COEF_FRAC, default 10, meaning the number of coefficient fraction bits dropped from the product; legal range 1..COEF_W-1.
REQ-004 The block SHALL expose parameter ROUND, default 0, where 0 is truncate (floor) and 1 is round-half-up.
REQ-005 The block SHALL expose parameter SAT, default 0, where 0 is wrap (keep low DATA_W bits) and 1 is saturate to the DATA_W signed range.
REQ-006 clk  in  1  sole clock; all state on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  in_a/in_b carry a sample.
REQ-009 in_ready  out  1  block accepts a sample this cycle.
REQ-010 in_a  in  DATA_W  signed data, same Q-format as out_z.
REQ-011 in_b  in  COEF_W  signed coefficient with COEF_FRAC fraction bits.
REQ-012 out_valid  out  1  out_z/out_ovf hold a result.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_z  out  DATA_W  signed scaled product.
REQ-015 out_ovf  out  1  overflow flag for the result on out_z.
REQ-016 clr_sticky  in  1  clears ovf_sticky.
REQ-017 ovf_sticky  out  1  set by any overflowed result transferred at the output.

Function
REQ-018 The datapath SHALL be a 3-stage pipeline: S1 registers in_a/in_b, S2 registers the full DATA_W+COEF_W-bit signed product, and S3 registers the rounded, shifted and saturated/wrapped result plus its overflow bit.
REQ-019 Latency SHALL be exactly 3 clk cycles from an input transfer (in_valid && in_ready) to out_valid for that sample when out_ready is held high.
REQ-020 A global advance SHALL be defined as adv = out_ready || !out_valid; all three stages (data and per-stage valid bits) SHALL update only when adv=1.
REQ-021 in_ready SHALL equal adv combinationally; a full pipeline SHALL sustain one sample per cycle with out_ready=1.
REQ-022 While out_valid=1 and out_ready=0, out_z, out_ovf and out_valid SHALL be held stable, and no input SHALL be accepted.
REQ-023 A bubble (in_valid=0 while adv=1) SHALL propagate as an invalid stage; results SHALL leave in input order with none lost or duplicated.
REQ-024 ROUND=0: r = P >>> COEF_FRAC (arithmetic shift, floor toward minus infinity).
REQ-025 ROUND=1: r = (P + 2^(COEF_FRAC-1)) >>> COEF_FRAC, computed at full width plus 1 bit so the add cannot overflow.
REQ-026 Overflow SHALL be flagged when r > 2^(DATA_W-1)-1 or r < -2^(DATA_W-1); it SHALL be computed identically in both SAT modes.
REQ-027 SAT=1: on overflow, out_z SHALL clamp to 2^(DATA_W-1)-1 or -2^(DATA_W-1) by the sign of r. SAT=0: out_z SHALL be r[DATA_W-1:0].
REQ-028 ovf_sticky SHALL set on a cycle with out_valid && out_ready && out_ovf. If clr_sticky is asserted in the same cycle, the set SHALL win; otherwise clr_sticky SHALL clear it.

Reset
REQ-029 While rst=1 at a clk edge, all stage valid bits, out_valid, out_ovf and ovf_sticky SHALL become 0 and out_z SHALL become 0; any in-flight samples SHALL be discarded.
REQ-030 in_ready SHALL be 1 during and directly after reset (because out_valid=0); no output transfer SHALL occur in the first cycle after reset is released.

Verification (defaults unless stated; values are raw integers)
REQ-031 Scaling: in_a=512 (1.0), in_b=512 (0.5) -> out_z=256, out_ovf=0, exactly 3 cycles after acceptance.
REQ-032 Rounding: in_a=3, in_b=512 -> ROUND=0 gives 1, ROUND=1 gives 2; in_a=-3, in_b=512 -> ROUND=0 gives -2, ROUND=1 gives -1.
REQ-033 Overflow: in_a=-4096, in_b=-1024 -> out_ovf=1 and ovf_sticky=1; SAT=1 gives out_z=4095, SAT=0 gives out_z=-4096; in_a=4095, in_b=-1024 -> out_z=-4095, out_ovf=0.
REQ-034 Backpressure: stream 10 consecutive samples with out_ready toggling pseudo-randomly -> all 10 results appear in order with correct values, and out_z stays stable throughout every stall.
REQ-035 Reset mid-stream: assert rst with 3 samples in flight -> no stale output appears after reset; the next accepted sample emerges 3 cycles later with the correct value.
REQ-036 Sticky: assert clr_sticky in the same cycle as an overflowed output transfer -> ovf_sticky=1; assert clr_sticky alone on a later cycle -> ovf_sticky=0 on the next cycle.
